// File: rtl/replay_buffer_mux_if.sv
// Shared-link bundle for the replay buffer mux: run enable and
// per-network spikes in, compressed replay stream and position out.
interface replay_buffer_mux_if #(
   parameter int Q = 2,
   parameter int GAMMA_CYCLE_LENGTH = 18
);
   localparam int CW = $clog2(GAMMA_CYCLE_LENGTH);

   logic                start_count;
   logic [Q-1:0][1:0]   in_spikes;
   logic [Q-1:0]        muxed_spikes;
   logic                net_sel;
   logic                replay_valid;
   logic [CW-1:0]       cycle_counter;

   modport master (
      output start_count, in_spikes,
      input  muxed_spikes, net_sel, replay_valid, cycle_counter
   );

   modport slave (
      input  start_count, in_spikes,
      output muxed_spikes, net_sel, replay_valid, cycle_counter
   );
endinterface

// File: rtl/replay_buffer_mux.sv
// Two-network spike capture into ping-pong banks, replayed 2:1
// time-compressed over one shared Q-wire bus in the next gamma cycle.
module replay_buffer_mux #(
   parameter int Q = 2,
   parameter int GAMMA_CYCLE_LENGTH = 18
) (
   input logic                clk,
   input logic                rst,
   replay_buffer_mux_if.slave bus
);
   localparam int G  = GAMMA_CYCLE_LENGTH;
   localparam int CW = $clog2(G);
   localparam logic [CW-1:0] LAST = CW'(G - 1);
   localparam logic [CW-1:0] HALF = CW'(G / 2);

   if (G % 2 != 0) begin : g_odd_gamma
      $error("GAMMA_CYCLE_LENGTH must be even");
   end

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_bank_q, wr_bank_d;
   logic [1:0][1:0][G-1:0][Q-1:0] bank_q, bank_d;
   logic [Q-1:0]  mux_q, mux_d;
   logic          sel_q, sel_d;
   logic          valid_q, valid_d;

   logic [Q-1:0]  in_n0, in_n1;
   logic          rd_bank;
   logic          net;
   logic [CW-1:0] pos;

   // Regroup wire-major input into one Q-bit word per network
   for (genvar gi = 0; gi < Q; gi++) begin : g_split
      assign in_n0[gi] = bus.in_spikes[gi][0];
      assign in_n1[gi] = bus.in_spikes[gi][1];
   end

   // Next state: capture, counter/bank swap, and pair-merged replay
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_bank_d = wr_bank_q;
      bank_d    = bank_q;
      mux_d     = '0;
      sel_d     = 1'b0;
      valid_d   = 1'b0;
      rd_bank   = ~wr_bank_q;
      net       = (cnt_q >= HALF);
      pos       = net ? CW'((cnt_q - HALF) << 1) : CW'(cnt_q << 1);
      if (!bus.start_count) begin
         state_d   = IDLE;
         cnt_d     = '0;
         wr_bank_d = 1'b0;
         bank_d    = '0;
      end else begin
         bank_d[wr_bank_q][0][cnt_q] = in_n0;
         bank_d[wr_bank_q][1][cnt_q] = in_n1;
         if (cnt_q == LAST) begin
            cnt_d     = '0;
            wr_bank_d = ~wr_bank_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         unique case (1'b1)
            state_q == IDLE: state_d = FILL;
            state_q == FILL: if (cnt_q == LAST) state_d = STREAM;
            default:         state_d = STREAM;
         endcase
         if (state_q == STREAM) begin
            mux_d   = bank_q[rd_bank][net][pos]
                    | bank_q[rd_bank][net][pos + 1'b1];
            sel_d   = ~net;
            valid_d = 1'b1;
         end
      end
   end

   // State, storage and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_bank_q <= 1'b0;
         bank_q    <= '0;
         mux_q     <= '0;
         sel_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_bank_q <= wr_bank_d;
         bank_q    <= bank_d;
         mux_q     <= mux_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.muxed_spikes  = mux_q;
   assign bus.net_sel       = sel_q;
   assign bus.replay_valid  = valid_q;
   assign bus.cycle_counter = cnt_q;
endmodule

// File: tb/tb_replay_buffer_mux.sv
// Directed bench for replay_buffer_mux: capture, compressed replay,
// OR merge, bank overwrite, async reset and run-enable drop.
module tb_replay_buffer_mux;
   localparam int Q = 2;
   localparam int G = 18;
   localparam int H = G / 2;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   replay_buffer_mux_if #(.Q(Q), .GAMMA_CYCLE_LENGTH(G)) bus ();

   replay_buffer_mux #(.Q(Q), .GAMMA_CYCLE_LENGTH(G)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " cnt"},   32'(bus.cycle_counter), 0);
      check({tag, " mux"},   32'(bus.muxed_spikes),  0);
      check({tag, " sel"},   32'(bus.net_sel),       0);
      check({tag, " valid"}, 32'(bus.replay_valid),  0);
   endtask

   // Drive ncyc clocks of one gamma (up to two stimulus words at
   // cycles c1/c2) and check the replay of the previous gamma:
   // valid flag ve, up to two expected pulses v1@s1, v2@s2.
   task automatic run_gamma(input string tag, input int ncyc,
                            input int c1, input logic [3:0] b1,
                            input int c2, input logic [3:0] b2,
                            input logic ve,
                            input int s1, input logic [1:0] v1,
                            input int s2, input logic [1:0] v2);
      logic [1:0] em;
      for (int c = 0; c < ncyc; c++) begin
         bus.start_count = 1'b1;
         bus.in_spikes   = '0;
         if (c == c1) bus.in_spikes = b1;
         if (c == c2) bus.in_spikes = bus.in_spikes | b2;
         step();
         em = 2'b00;
         if (ve && c == s1) em = em | v1;
         if (ve && c == s2) em = em | v2;
         check($sformatf("%s mux c%0d", tag, c),
               32'(bus.muxed_spikes), 32'(em));
         check($sformatf("%s sel c%0d", tag, c),
               32'(bus.net_sel), 32'(ve && c < H));
         check($sformatf("%s valid c%0d", tag, c),
               32'(bus.replay_valid), 32'(ve));
         check($sformatf("%s cnt c%0d", tag, c),
               32'(bus.cycle_counter), (c + 1) % G);
      end
      bus.in_spikes = '0;
   endtask

   initial begin
      rst             = 1'b1;
      bus.start_count = 1'b0;
      bus.in_spikes   = '0;
      step();
      step();
      check_idle("reset");
      rst = 1'b0;
      step();
      check_idle("idle");

      // gamma 0 empty, then single spikes, merge, overwrite, both nets
      run_gamma("g0", G, -1, 4'h0, -1, 4'h0, 1'b0, -1, 2'b00, -1, 2'b00);
      run_gamma("g1", G,  4, 4'h1, -1, 4'h0, 1'b1, -1, 2'b00, -1, 2'b00);
      run_gamma("g2", G,  7, 4'h8, -1, 4'h0, 1'b1,  2, 2'b01, -1, 2'b00);
      run_gamma("g3", G,  4, 4'h1,  5, 4'h1, 1'b1, 12, 2'b10, -1, 2'b00);
      run_gamma("g4", G, -1, 4'h0, -1, 4'h0, 1'b1,  2, 2'b01, -1, 2'b00);
      run_gamma("g5", G, 10, 4'hf, -1, 4'h0, 1'b1, -1, 2'b00, -1, 2'b00);
      run_gamma("g6", G,  0, 4'h4, 17, 4'h2, 1'b1,  5, 2'b11, 14, 2'b11);
      run_gamma("g7", G,  3, 4'h1, -1, 4'h0, 1'b1,  0, 2'b10, 17, 2'b01);
      run_gamma("g8", 10, -1, 4'h0, -1, 4'h0, 1'b1, 1, 2'b01, -1, 2'b00);

      // run enable dropped at cycle 10 of a streaming gamma
      bus.start_count = 1'b0;
      step();
      check_idle("drop");
      run_gamma("r0", G, -1, 4'h0, -1, 4'h0, 1'b0, -1, 2'b00, -1, 2'b00);
      run_gamma("r1", 5,  2, 4'h1, -1, 4'h0, 1'b1, -1, 2'b00, -1, 2'b00);

      // async reset between edges while streaming
      #2;
      rst = 1'b1;
      #1;
      check_idle("async");
      bus.start_count = 1'b0;
      step();
      rst = 1'b0;
      run_gamma("a0", G, -1, 4'h0, -1, 4'h0, 1'b0, -1, 2'b00, -1, 2'b00);
      run_gamma("a1", G, -1, 4'h0, -1, 4'h0, 1'b1, -1, 2'b00, -1, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
